// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch pipeline: fetch-state encoding, PC step,
// reset PC and the NOP encoding used to blank the IF/ID register.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0;
    localparam int          PC_STEP   = 4;
    localparam logic [31:0] INSTR_NOP = 32'h0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats freeze, and an
// unfrozen cycle without a new instruction retires the current one.
module if_id_reg #(
    parameter int BIT_NUMBER = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic [BIT_NUMBER-1:0] load_pc,
    input  logic [BIT_NUMBER-1:0] load_instr,
    output logic [BIT_NUMBER-1:0] pc_out,
    output logic [BIT_NUMBER-1:0] instruction,
    output logic                  valid
);
    import if_stage_pkg::*;

    localparam logic [BIT_NUMBER-1:0] NOP = BIT_NUMBER'(INSTR_NOP);

    logic [BIT_NUMBER-1:0] pc_reg;
    logic [BIT_NUMBER-1:0] instr_reg;
    logic                  valid_reg;

    // pc_out is left untouched on flush/consume; only valid and the word are cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg    <= '0;
            instr_reg <= NOP;
            valid_reg <= 1'b0;
        end else if (flush) begin
            instr_reg <= NOP;
            valid_reg <= 1'b0;
        end else if (load) begin
            pc_reg    <= load_pc;
            instr_reg <= load_instr;
            valid_reg <= 1'b1;
        end else if (!freeze) begin
            instr_reg <= NOP;
            valid_reg <= 1'b0;
        end
    end

    assign pc_out      = pc_reg;
    assign instruction = instr_reg;
    assign valid       = valid_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding fetch
// handshake, a one-entry skid buffer and branch redirect with response kill.
module if_stage #(
    parameter int                    BIT_NUMBER = 32,
    parameter logic [BIT_NUMBER-1:0] RESET_PC   = BIT_NUMBER'(if_stage_pkg::RESET_PC),
    parameter int                    PC_STEP    = if_stage_pkg::PC_STEP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [BIT_NUMBER-1:0] branch_addr,
    output logic                  imem_req,
    output logic [BIT_NUMBER-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [BIT_NUMBER-1:0] imem_rdata,
    output logic [BIT_NUMBER-1:0] pc_out,
    output logic [BIT_NUMBER-1:0] instruction,
    output logic                  valid
);
    import if_stage_pkg::*;

    localparam logic [BIT_NUMBER-1:0] STEP = BIT_NUMBER'(PC_STEP);

    fetch_state_e          state_reg;
    logic [BIT_NUMBER-1:0] pc_reg;
    logic [BIT_NUMBER-1:0] req_pc_reg;
    logic                  kill_reg;
    logic [BIT_NUMBER-1:0] skid_pc_reg;
    logic [BIT_NUMBER-1:0] skid_instr_reg;

    logic [BIT_NUMBER-1:0] branch_target;
    logic [BIT_NUMBER-1:0] pc_inc;
    logic                  id_can_accept;
    logic                  id_load;
    logic [BIT_NUMBER-1:0] id_load_pc;
    logic [BIT_NUMBER-1:0] id_load_instr;
    logic                  unused_branch_lsb;

    assign branch_target     = {branch_addr[BIT_NUMBER-1:2], 2'b00};
    assign unused_branch_lsb = ^branch_addr[1:0];
    assign pc_inc            = pc_reg + STEP;

    // imem_req is gated by rst so no request is visible while reset is held
    assign imem_req  = rst && (state_reg == FETCH);
    assign imem_addr = pc_reg;

    assign id_can_accept = !freeze || !valid;

    always_comb begin
        id_load       = 1'b0;
        id_load_pc    = req_pc_reg + STEP;
        id_load_instr = imem_rdata;
        if (state_reg == HOLD) begin
            id_load_pc    = skid_pc_reg;
            id_load_instr = skid_instr_reg;
            id_load       = !freeze;
        end else if (state_reg == WAIT) begin
            id_load = imem_rvalid && !kill_reg && id_can_accept;
        end
        if (branch_taken) begin
            id_load = 1'b0;
        end
    end

    // HOLD implies the skid entry is full; leaving HOLD empties it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= FETCH;
            pc_reg         <= RESET_PC;
            req_pc_reg     <= '0;
            kill_reg       <= 1'b0;
            skid_pc_reg    <= '0;
            skid_instr_reg <= '0;
        end else if (branch_taken) begin
            pc_reg <= branch_target;
            case (state_reg)
                FETCH: begin
                    if (imem_ready) begin
                        req_pc_reg <= pc_reg;
                        kill_reg   <= 1'b1;
                        state_reg  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        kill_reg  <= 1'b0;
                        state_reg <= FETCH;
                    end else begin
                        kill_reg <= 1'b1;
                    end
                end
                default: state_reg <= FETCH;
            endcase
        end else begin
            case (state_reg)
                FETCH: begin
                    if (imem_ready) begin
                        req_pc_reg <= pc_reg;
                        pc_reg     <= pc_inc;
                        state_reg  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_reg) begin
                            kill_reg  <= 1'b0;
                            state_reg <= FETCH;
                        end else if (id_can_accept) begin
                            state_reg <= FETCH;
                        end else begin
                            skid_pc_reg    <= req_pc_reg + STEP;
                            skid_instr_reg <= imem_rdata;
                            state_reg      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        state_reg <= FETCH;
                    end
                end
                default: state_reg <= FETCH;
            endcase
        end
    end

    if_id_reg #(
        .BIT_NUMBER(BIT_NUMBER)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (id_load),
        .freeze     (freeze),
        .flush      (branch_taken),
        .load_pc    (id_load_pc),
        .load_instr (id_load_instr),
        .pc_out     (pc_out),
        .instruction(instruction),
        .valid      (valid)
    );

endmodule
